lcd_stream_sched: RTL and testbench

//  Pixel-clock-domain scheduler that sequences the LCD read path: flushes the pixel FIFO, prefills it,

---
 rtl/lcd_pkg.sv | 15 +
 rtl/lcd_sat_cnt.sv | 34 +++
 rtl/lcd_stream_sched.sv | 152 +++++++++++++++
 tb/tb_lcd_stream_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD read-path scheduler: FSM encodings and 480x272 panel defaults.
package lcd_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_PREFILL = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam int LCD_CNT_W         = 10;
  localparam int LCD_PREFILL_LEVEL = 512;
  localparam int LCD_FLUSH_CYCLES  = 16;
  localparam int LCD_H_ACTIVE      = 480;
  localparam int LCD_V_ACTIVE      = 272;

endpackage

// File: rtl/lcd_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module lcd_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lcd_stream_sched.sv
// Pixel-clock scheduler for the LCD read path: flush, prefill, release the driver with a
// frame-sync pulse, gate FIFO reads, and recover from underflow or frame misalignment.
module lcd_stream_sched
  import lcd_pkg::*;
#(
  parameter int CNT_W         = LCD_CNT_W,
  parameter int PREFILL_LEVEL = LCD_PREFILL_LEVEL,
  parameter int FLUSH_CYCLES  = LCD_FLUSH_CYCLES,
  parameter int H_ACTIVE      = LCD_H_ACTIVE,
  parameter int V_ACTIVE      = LCD_V_ACTIVE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] fifo_rd_cnt,
  input  logic             fifo_empty,
  input  logic             lcd_request,
  input  logic             lcd_vs_start,
  output logic             fifo_rd_en,
  output logic             fifo_flush,
  output logic             lcd_run,
  output logic             lcd_framesync,
  output logic [15:0]      underflow_cnt,
  output logic [15:0]      frame_cnt,
  output logic [1:0]       state
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int PIX_W     = $clog2(FRAME_PIX + 2);
  localparam int FC_W      = $clog2(FLUSH_CYCLES + 1);

  localparam logic [PIX_W-1:0] PIX_FRAME  = PIX_W'(FRAME_PIX);
  localparam logic [PIX_W-1:0] PIX_SAT    = PIX_W'(FRAME_PIX + 1);
  localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] PREFILL_TH = CNT_W'(PREFILL_LEVEL);

  logic [1:0]       state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [PIX_W-1:0] pixel_cnt_q, pixel_cnt_d;
  logic             first_vs_q, first_vs_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             stop_q, stop_d;
  logic             flush_q, run_q, framesync_q;

  logic in_run, underflow, stop_now;

  assign in_run     = (state_q == ST_RUN);
  assign fifo_rd_en = in_run & lcd_request & ~fifo_empty;
  assign underflow  = in_run & lcd_request & fifo_empty;
  // A stop request is remembered until the frame boundary even if enable returns high.
  assign stop_now   = stop_q | ~enable;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pixel_cnt_d = pixel_cnt_q;
    first_vs_d  = first_vs_q;
    frame_cnt_d = frame_cnt_q;
    stop_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (flush_cnt_q == '0) begin
          state_d = ST_PREFILL;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      ST_PREFILL: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fifo_rd_cnt >= PREFILL_TH) begin
          state_d     = ST_RUN;
          pixel_cnt_d = '0;
          first_vs_d  = 1'b1;
        end
      end
      ST_RUN: begin
        stop_d = stop_now;
        // Saturate one past a full frame so overruns still fail the frame check.
        if (fifo_rd_en && (pixel_cnt_q != PIX_SAT)) begin
          pixel_cnt_d = pixel_cnt_q + PIX_W'(1);
        end
        if (underflow) begin
          state_d     = stop_now ? ST_IDLE : ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else if (lcd_vs_start) begin
          pixel_cnt_d = '0;
          if (first_vs_q) begin
            first_vs_d = 1'b0;
          end else if (pixel_cnt_q == PIX_FRAME) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
          if (stop_now) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      pixel_cnt_q <= '0;
      first_vs_q  <= 1'b1;
      frame_cnt_q <= '0;
      stop_q      <= 1'b0;
      flush_q     <= 1'b0;
      run_q       <= 1'b0;
      framesync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pixel_cnt_q <= pixel_cnt_d;
      first_vs_q  <= first_vs_d;
      frame_cnt_q <= frame_cnt_d;
      stop_q      <= stop_d;
      flush_q     <= (state_d == ST_FLUSH);
      // Driver is released the cycle after the frame-sync pulse has cleared its counters.
      run_q       <= (state_d == ST_RUN) && (state_q == ST_RUN);
      framesync_q <= (state_d == ST_RUN) && (state_q == ST_PREFILL);
    end
  end

  lcd_sat_cnt #(.W(16)) u_underflow_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (underflow),
    .clr_i (1'b0),
    .cnt_o (underflow_cnt)
  );

  assign fifo_flush    = flush_q;
  assign lcd_run       = run_q;
  assign lcd_framesync = framesync_q;
  assign frame_cnt     = frame_cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_lcd_stream_sched.sv
// Directed bench for lcd_stream_sched on a 4x2 panel, prefill 8, flush 4 cycles.
module tb_lcd_stream_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [9:0]  fifo_rd_cnt;
  logic        fifo_empty;
  logic        lcd_request;
  logic        lcd_vs_start;
  logic        fifo_rd_en;
  logic        fifo_flush;
  logic        lcd_run;
  logic        lcd_framesync;
  logic [15:0] underflow_cnt;
  logic [15:0] frame_cnt;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lcd_stream_sched #(
    .CNT_W(10), .PREFILL_LEVEL(8), .FLUSH_CYCLES(4), .H_ACTIVE(4), .V_ACTIVE(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .fifo_rd_cnt   (fifo_rd_cnt),
    .fifo_empty    (fifo_empty),
    .lcd_request   (lcd_request),
    .lcd_vs_start  (lcd_vs_start),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_flush    (fifo_flush),
    .lcd_run       (lcd_run),
    .lcd_framesync (lcd_framesync),
    .underflow_cnt (underflow_cnt),
    .frame_cnt     (frame_cnt),
    .state         (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    lcd_vs_start = 1'b1;
    tick();
    lcd_vs_start = 1'b0;
  endtask

  task automatic send_pixels(input int n, output int reads);
    reads = 0;
    for (int i = 0; i < n; i++) begin
      lcd_request = 1'b1;
      #1;
      if (fifo_rd_en) reads++;
      tick();
    end
    lcd_request = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int k;
    k = 0;
    while (!(state == 2'd3 && lcd_run) && k < 50) begin
      tick();
      k++;
    end
    chk(tag, (state == 2'd3 && lcd_run), 1);
  endtask

  int flushes;
  int reads;

  initial begin
    rst_n = 1'b0; enable = 1'b0; fifo_rd_cnt = 10'd7; fifo_empty = 1'b1;
    lcd_request = 1'b0; lcd_vs_start = 1'b0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_flush", fifo_flush, 0);
    chk("rst_run", lcd_run, 0);
    chk("rst_fsync", lcd_framesync, 0);
    chk("rst_ucnt", underflow_cnt, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_rden", fifo_rd_en, 0);
    rst_n = 1'b1;
    tick();

    // Flush length and prefill hold at 7
    enable = 1'b1;
    tick();
    flushes = 0;
    for (int i = 0; i < 10; i++) begin
      if (fifo_flush) flushes++;
      tick();
    end
    chk("flush_len", flushes, 4);
    chk("prefill_hold", state, 2);
    chk("prefill_fsync", lcd_framesync, 0);
    chk("prefill_run", lcd_run, 0);
    fifo_rd_cnt = 10'd8;
    tick();
    chk("fsync_pulse", lcd_framesync, 1);
    chk("fsync_state", state, 3);
    chk("fsync_run", lcd_run, 0);
    tick();
    chk("fsync_drop", lcd_framesync, 0);
    chk("run_on", lcd_run, 1);

    // One good frame after the ignored first vs_start
    fifo_empty = 1'b0;
    vs_pulse();
    send_pixels(8, reads);
    chk("reads_8", reads, 8);
    vs_pulse();
    chk("frame_1", frame_cnt, 1);
    chk("ucnt_0", underflow_cnt, 0);
    chk("state_run", state, 3);

    // Underflow
    fifo_empty = 1'b1;
    lcd_request = 1'b1;
    #1;
    chk("uf_rden", fifo_rd_en, 0);
    tick();
    lcd_request = 1'b0;
    fifo_empty = 1'b0;
    chk("uf_cnt", underflow_cnt, 1);
    chk("uf_run", lcd_run, 0);
    chk("uf_state", state, 1);
    flushes = fifo_flush ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fifo_flush) flushes++;
    end
    chk("uf_flush_len", flushes, 4);
    chk("uf_recover", (state == 2'd3 && lcd_run), 1);

    // Short frame
    vs_pulse();
    send_pixels(7, reads);
    vs_pulse();
    chk("short_state", state, 1);
    chk("short_frame", frame_cnt, 1);
    wait_run("short_recover");

    // Long frame
    vs_pulse();
    send_pixels(9, reads);
    chk("long_reads", reads, 9);
    vs_pulse();
    chk("long_state", state, 1);
    chk("long_frame", frame_cnt, 1);
    wait_run("long_recover");

    // Good frame after recovery
    vs_pulse();
    send_pixels(8, reads);
    vs_pulse();
    chk("frame_2", frame_cnt, 2);

    // Graceful stop mid-frame
    send_pixels(3, reads);
    enable = 1'b0;
    tick(); tick();
    chk("stop_run_hold", lcd_run, 1);
    enable = 1'b1;
    send_pixels(5, reads);
    chk("stop_run_hold2", lcd_run, 1);
    vs_pulse();
    chk("stop_state", state, 0);
    chk("stop_run", lcd_run, 0);
    chk("stop_frame", frame_cnt, 3);
    chk("stop_ucnt", underflow_cnt, 1);

    // Asynchronous reset while flushing
    enable = 1'b1;
    tick(); tick();
    chk("pre_rst_flush", fifo_flush, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_flush", fifo_flush, 0);
    chk("arst_state", state, 0);
    chk("arst_run", lcd_run, 0);
    chk("arst_ucnt", underflow_cnt, 0);
    chk("arst_fcnt", frame_cnt, 0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
